// File: rtl/itcm_responder_pkg.sv
// Shared definitions for the instruction TCM responder and the fetch unit:
// default base address, legal latency range, FSM encoding and abort counter.
package itcm_responder_pkg;

    localparam logic [63:0] ITCM_BASE_DEFAULT = 64'h0000_0000_8000_0000;
    localparam int          LAT_MIN           = 1;
    localparam int          LAT_MAX           = 3;
    localparam int          ABORT_CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } itcm_state_e;

    // Saturating increment: the statistic sticks at all-ones instead of wrapping.
    function automatic logic [ABORT_CNT_W-1:0] abort_cnt_inc(input logic [ABORT_CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/itcm_responder_sram_1r1w.sv
// Instruction TCM storage array: one synchronous read port, one byte-strobed
// write port. A read and write to the same word on one edge returns the old
// word. The read register only updates on rd_en, so it holds the last word read.
module itcm_responder_sram_1r1w #(
    parameter int DW = 64,
    parameter int AW = 14
) (
    input  logic              CLK,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_strb
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_data_q;

    // Synchronous read; non-blocking update gives read-before-write on collision.
    always_ff @(posedge CLK) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    // Byte-strobed write; untouched lanes keep their previous contents.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < DW/8; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/itcm_responder.sv
// Instruction TCM responder for the fetch read channel. Always ready: every
// ARVALID cycle captures a new request, superseding whatever was pending or
// visible. The word is read from the array at acceptance, so later preload
// writes cannot disturb an in-flight or held response.
module itcm_responder
    import itcm_responder_pkg::*;
#(
    parameter int          DW   = 64,
    parameter int          AW   = 14,
    parameter logic [63:0] BASE = ITCM_BASE_DEFAULT,
    parameter int          LAT  = 1
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic [63:0]             S_IFU_ARADDR,
    input  logic                    S_IFU_ARVALID,
    input  logic                    S_IFU_RREADY,
    output logic                    S_IFU_RVALID,
    output logic [DW-1:0]           S_IFU_RDATA,
    output logic                    S_IFU_RERR,
    input  logic                    pl_wen,
    input  logic [AW-1:0]           pl_waddr,
    input  logic [DW-1:0]           pl_wdata,
    input  logic [DW/8-1:0]         pl_wstrb,
    output logic [ABORT_CNT_W-1:0]  stat_abort_cnt
);

    // Latency outside the legal range is pulled back to the nearest legal value.
    localparam int         LAT_EFF  = (LAT < LAT_MIN) ? LAT_MIN : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
    localparam int         BYTE_SH  = $clog2(DW/8);
    localparam logic [1:0] AGE_LAST = 2'(LAT_EFF - 1);

    logic [63:0]            addr_off;
    logic [63:0]            word_off;
    logic                   in_range;
    logic [AW-1:0]          rd_idx;
    logic                   rd_en;
    logic                   abort;
    logic [DW-1:0]          sram_rdata;

    itcm_state_e            state_q,     state_d;
    logic [1:0]             age_q,       age_d;
    logic                   rvalid_q,    rvalid_d;
    logic                   rerr_q,      rerr_d;
    logic [ABORT_CNT_W-1:0] abort_cnt_q, abort_cnt_d;

    // Address decode: below BASE wraps to a huge offset, so the upper-bits
    // test alone rejects both underflow and overflow of the array.
    assign addr_off = S_IFU_ARADDR - BASE;
    assign word_off = addr_off >> BYTE_SH;
    assign in_range = (S_IFU_ARADDR >= BASE) && (word_off[63:AW] == '0);
    assign rd_idx   = word_off[AW-1:0];

    // Next-state logic: a new request pre-empts everything, otherwise age or drain.
    always_comb begin
        state_d     = state_q;
        age_d       = age_q;
        rvalid_d    = rvalid_q;
        rerr_d      = rerr_q;
        abort_cnt_d = abort_cnt_q;
        rd_en       = 1'b0;
        abort       = 1'b0;

        if (S_IFU_ARVALID) begin
            abort  = ((state_q == ST_RESP) && !S_IFU_RREADY) || (state_q == ST_WAIT);
            rd_en  = in_range;
            rerr_d = !in_range;
            if (abort) begin
                abort_cnt_d = abort_cnt_inc(abort_cnt_q);
            end
            if (LAT_EFF == 1) begin
                state_d  = ST_RESP;
                rvalid_d = 1'b1;
            end else begin
                state_d  = ST_WAIT;
                age_d    = 2'd1;
                rvalid_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (age_q == AGE_LAST) begin
                        state_d  = ST_RESP;
                        rvalid_d = 1'b1;
                    end else begin
                        age_d = age_q + 2'd1;
                    end
                end
                ST_RESP: begin
                    if (S_IFU_RREADY) begin
                        state_d  = ST_IDLE;
                        rvalid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control and response-status registers; reset drops RVALID at once.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            age_q       <= 2'd0;
            rvalid_q    <= 1'b0;
            rerr_q      <= 1'b0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            age_q       <= age_d;
            rvalid_q    <= rvalid_d;
            rerr_q      <= rerr_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    itcm_responder_sram_1r1w #(
        .DW (DW),
        .AW (AW)
    ) u_sram (
        .CLK     (CLK),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (sram_rdata),
        .wr_en   (pl_wen),
        .wr_addr (pl_waddr),
        .wr_data (pl_wdata),
        .wr_strb (pl_wstrb)
    );

    // Data is exposed only with a valid in-range response, so reset and
    // error responses read as zero without resetting the array path.
    assign S_IFU_RDATA    = (rvalid_q && !rerr_q) ? sram_rdata : '0;
    assign S_IFU_RVALID   = rvalid_q;
    assign S_IFU_RERR     = rerr_q;
    assign stat_abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_itcm_responder.sv
// Bench for itcm_responder: two instances (LAT=1 and LAT=3) share one stimulus
// stream and are compared every cycle against a time-based reference model.
module tb_itcm_responder;

    localparam int          DW   = 64;
    localparam int          AW   = 14;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] CAP  = 64'd131072;
    localparam logic [63:0] W0   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W1   = 64'h0000_0013_0010_0093;
    localparam int          TOP  = 16383;

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic [63:0]       araddr = '0;
    logic              arvalid = 1'b0;
    logic              rready = 1'b0;
    logic              pl_wen = 1'b0;
    logic [AW-1:0]     pl_waddr = '0;
    logic [DW-1:0]     pl_wdata = '0;
    logic [DW/8-1:0]   pl_wstrb = '0;

    logic [1:0]        rvalid_o;
    logic [1:0]        rerr_o;
    logic [DW-1:0]     rdata_o [2];
    logic [15:0]       cnt_o   [2];

    always #5 CLK = ~CLK;

    itcm_responder #(.DW(DW), .AW(AW), .BASE(BASE), .LAT(1)) u_lat1 (
        .CLK(CLK), .RSTn(RSTn),
        .S_IFU_ARADDR(araddr), .S_IFU_ARVALID(arvalid), .S_IFU_RREADY(rready),
        .S_IFU_RVALID(rvalid_o[0]), .S_IFU_RDATA(rdata_o[0]), .S_IFU_RERR(rerr_o[0]),
        .pl_wen(pl_wen), .pl_waddr(pl_waddr), .pl_wdata(pl_wdata), .pl_wstrb(pl_wstrb),
        .stat_abort_cnt(cnt_o[0])
    );

    itcm_responder #(.DW(DW), .AW(AW), .BASE(BASE), .LAT(3)) u_lat3 (
        .CLK(CLK), .RSTn(RSTn),
        .S_IFU_ARADDR(araddr), .S_IFU_ARVALID(arvalid), .S_IFU_RREADY(rready),
        .S_IFU_RVALID(rvalid_o[1]), .S_IFU_RDATA(rdata_o[1]), .S_IFU_RERR(rerr_o[1]),
        .pl_wen(pl_wen), .pl_waddr(pl_waddr), .pl_wdata(pl_wdata), .pl_wstrb(pl_wstrb),
        .stat_abort_cnt(cnt_o[1])
    );

    // Reference model state: one pending and one visible slot per instance.
    int          lat_m [2] = '{1, 3};
    bit          vis_v [2];
    logic [63:0] vis_d [2];
    bit          vis_e [2];
    bit          pend_v [2];
    int          pend_due [2];
    logic [63:0] pend_d [2];
    bit          pend_e [2];
    int          cnt_m [2];
    logic [63:0] mem_m [int];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit ref_in_range(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < CAP);
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        int idx;
        if (!ref_in_range(a)) return 64'h0;
        idx = int'((a - BASE) / 64'd8);
        return mem_m.exists(idx) ? mem_m[idx] : 64'h0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            vis_v[d]  = 1'b0;
            pend_v[d] = 1'b0;
            cnt_m[d]  = 0;
        end
    endtask

    // One clock edge of the reference: requests read memory before any preload lands.
    task automatic model_edge();
        int widx;
        for (int d = 0; d < 2; d++) begin
            if (arvalid) begin
                if (vis_v[d] && !rready && cnt_m[d] < 65535) cnt_m[d]++;
                if (pend_v[d] && cnt_m[d] < 65535) cnt_m[d]++;
                vis_v[d]    = 1'b0;
                pend_v[d]   = 1'b1;
                pend_due[d] = cyc + lat_m[d] - 1;
                pend_d[d]   = ref_read(araddr);
                pend_e[d]   = !ref_in_range(araddr);
            end else if (vis_v[d] && rready) begin
                vis_v[d] = 1'b0;
            end
        end
        if (pl_wen) begin
            widx = int'(pl_waddr);
            if (!mem_m.exists(widx)) mem_m[widx] = 64'h0;
            for (int b = 0; b < 8; b++) begin
                if (pl_wstrb[b]) mem_m[widx][b*8 +: 8] = pl_wdata[b*8 +: 8];
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (pend_v[d] && pend_due[d] <= cyc) begin
                vis_v[d]  = 1'b1;
                vis_d[d]  = pend_d[d];
                vis_e[d]  = pend_e[d];
                pend_v[d] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("rvalid_lat%0d", lat_m[d]), rvalid_o[d], vis_v[d]);
            if (vis_v[d]) begin
                check_val($sformatf("rdata_lat%0d", lat_m[d]), rdata_o[d], vis_d[d]);
                check_val($sformatf("rerr_lat%0d", lat_m[d]), rerr_o[d], vis_e[d]);
            end
            check_val($sformatf("abort_cnt_lat%0d", lat_m[d]), cnt_o[d], cnt_m[d]);
        end
    endtask

    // Advance one clock, update the model from the pre-edge inputs, then compare.
    task automatic step();
        @(posedge CLK);
        cyc++;
        if (!RSTn) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic rr);
        arvalid = 1'b0;
        pl_wen  = 1'b0;
        rready  = rr;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic req(input logic [63:0] a, input logic rr);
        arvalid = 1'b1;
        araddr  = a;
        rready  = rr;
        step();
        arvalid = 1'b0;
    endtask

    task automatic preload(input int idx, input logic [63:0] data, input logic [7:0] strb);
        pl_wen   = 1'b1;
        pl_waddr = AW'(idx);
        pl_wdata = data;
        pl_wstrb = strb;
        step();
        pl_wen = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            check_val("reset_rvalid", rvalid_o[d], 0);
            check_val("reset_rdata", rdata_o[d], 0);
            check_val("reset_rerr", rerr_o[d], 0);
            check_val("reset_cnt", cnt_o[d], 0);
        end
        idle(2, 1'b0);
        RSTn = 1'b1;

        // Load the words exercised below, including the last word of the array.
        preload(0, W0, 8'hFF);
        preload(1, W1, 8'hFF);
        for (int i = 2; i < 16; i++) preload(i, {$urandom, $urandom}, 8'hFF);
        preload(TOP, {$urandom, $urandom}, 8'hFF);
        check_val("after_preload_rvalid", rvalid_o[0], 0);

        // Single fetch of word 1.
        req(BASE + 64'd8, 1'b1);
        check_val("fetch_w1_data", rdata_o[0], W1);
        check_val("fetch_w1_err", rerr_o[0], 0);
        idle(1, 1'b1);
        check_val("fetch_w1_drop", rvalid_o[0], 0);
        idle(3, 1'b1);

        // Hold under backpressure while word 1 is overwritten.
        req(BASE + 64'd8, 1'b0);
        pl_wen = 1'b1; pl_waddr = AW'(1); pl_wdata = 64'hDEAD_BEEF_CAFE_F00D; pl_wstrb = 8'hFF;
        rready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        pl_wen = 1'b0;
        check_val("hold_lat1_data", rdata_o[0], W1);
        check_val("hold_lat3_data", rdata_o[1], W1);
        idle(1, 1'b1);
        check_val("hold_release", rvalid_o[0], 0);
        check_val("hold_no_abort", cnt_o[0], 0);
        idle(3, 1'b1);

        // Back-to-back supersede with and without consumption.
        req(BASE, 1'b0);
        check_val("b2b_a_data", rdata_o[0], W0);
        req(BASE + 64'd8, 1'b0);
        check_val("b2b_b_data", rdata_o[0], 64'hDEAD_BEEF_CAFE_F00D);
        check_val("b2b_abort_lat1", cnt_o[0], 1);
        check_val("b2b_abort_lat3", cnt_o[1], 1);
        idle(4, 1'b1);
        req(BASE, 1'b0);
        req(BASE + 64'd8, 1'b1);
        check_val("b2b_consumed_lat1", cnt_o[0], 1);
        check_val("b2b_consumed_lat3", cnt_o[1], 2);
        idle(4, 1'b1);

        // Out-of-range on both sides, then an unaligned in-range address.
        req(64'h0000_0000_7FFF_FFF8, 1'b1);
        check_val("oor_low_err", rerr_o[0], 1);
        check_val("oor_low_data", rdata_o[0], 0);
        idle(3, 1'b1);
        req(BASE + CAP, 1'b1);
        check_val("oor_high_err", rerr_o[0], 1);
        check_val("oor_high_data", rdata_o[0], 0);
        idle(3, 1'b1);
        req(BASE + CAP - 64'd8, 1'b1);
        check_val("top_word_err", rerr_o[0], 0);
        idle(3, 1'b1);
        req(64'h0000_0000_8000_0004, 1'b1);
        check_val("unaligned_data", rdata_o[0], W0);
        check_val("unaligned_err", rerr_o[0], 0);
        idle(3, 1'b1);

        // LAT=3: A is superseded by B and never shows.
        req(BASE, 1'b0);
        req(BASE + 64'd8, 1'b0);
        idle(1, 1'b0);
        check_val("lat3_a_hidden", rvalid_o[1], 0);
        idle(1, 1'b0);
        check_val("lat3_b_valid", rvalid_o[1], 1);
        check_val("lat3_b_data", rdata_o[1], 64'hDEAD_BEEF_CAFE_F00D);
        idle(4, 1'b1);

        // Asynchronous reset while responses are visible and in flight.
        req(BASE, 1'b0);
        req(BASE + 64'd8, 1'b0);
        check_val("pre_reset_valid", rvalid_o[0], 1);
        RSTn = 1'b0;
        #1;
        check_val("async_reset_lat1", rvalid_o[0], 0);
        check_val("async_reset_lat3", rvalid_o[1], 0);
        check_val("async_reset_cnt", cnt_o[0], 0);
        model_reset();
        idle(2, 1'b0);
        RSTn = 1'b1;
        idle(5, 1'b0);
        check_val("post_reset_lat3", rvalid_o[1], 0);

        // Randomized traffic with preloads in every state.
        for (int n = 0; n < 600; n++) begin
            int sel;
            sel     = $urandom_range(0, 9);
            arvalid = ($urandom_range(0, 1) == 1);
            rready  = ($urandom_range(0, 3) != 0);
            if (sel <= 6)      araddr = BASE + 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7));
            else if (sel == 7) araddr = BASE + CAP - 64'd8 + 64'($urandom_range(0, 7));
            else if (sel == 8) araddr = BASE - 64'd8 * 64'($urandom_range(1, 4));
            else               araddr = BASE + CAP + 64'd8 * 64'($urandom_range(0, 3));
            pl_wen   = ($urandom_range(0, 3) == 0);
            pl_waddr = ($urandom_range(0, 7) == 0) ? AW'(TOP) : AW'($urandom_range(0, 15));
            pl_wdata = {$urandom, $urandom};
            pl_wstrb = 8'($urandom);
            step();
        end
        idle(4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
